// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side handshake bundle for the TX arbiter
interface uart_tx_arbiter_if #(
    parameter int MESSAGE_SIZE = 512,
    parameter int HEADER_SIZE  = 32,
    parameter int NUM_REQ      = 3
);
    logic [NUM_REQ-1:0]              req_valid_in;
    logic [NUM_REQ-1:0]              req_ready_out;
    logic [NUM_REQ*MESSAGE_SIZE-1:0] req_message_in;
    logic [NUM_REQ*HEADER_SIZE-1:0]  req_header_in;
    logic                            tx_valid_out;
    logic                            tx_ready_in;
    logic [MESSAGE_SIZE-1:0]         tx_message_out;
    logic [HEADER_SIZE-1:0]          tx_header_out;
    logic                            remote_stall_in;
    logic [1:0]                      grant_id_out;
    logic [15:0]                     sent_count_out;
    modport master (
        input  req_valid_in, req_message_in, req_header_in, tx_ready_in, remote_stall_in,
        output req_ready_out, tx_valid_out, tx_message_out, tx_header_out, grant_id_out, sent_count_out
    );
    modport slave (
        output req_valid_in, req_message_in, req_header_in, tx_ready_in, remote_stall_in,
        input  req_ready_out, tx_valid_out, tx_message_out, tx_header_out, grant_id_out, sent_count_out
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter holding one tagged message at a time for a UART TX port
module uart_tx_arbiter #(
    parameter int MESSAGE_SIZE = 512,
    parameter int HEADER_SIZE  = 32,
    parameter int NUM_REQ      = 3
) (
    input logic               clk_in,
    input logic               rst_in,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLD, PAUSED} state_t;
    state_t                  state_q, state_d;
    logic [1:0]              last_grant_q, last_grant_d;
    logic [1:0]              winner_q, winner_d;
    logic [1:0]              grant_id_q, grant_id_d;
    logic [MESSAGE_SIZE-1:0] msg_q, msg_d;
    logic [HEADER_SIZE-1:0]  hdr_q, hdr_d;
    logic [15:0]             sent_count_q, sent_count_d;
    logic [1:0]              pick, rr_idx;
    logic                    win_valid;

    // round-robin search: smallest offset after last_grant that is valid wins
    always_comb begin
        pick   = '0;
        rr_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = 2'((int'(last_grant_q) + k) % NUM_REQ);
            if (bus.req_valid_in[rr_idx]) pick = rr_idx;
        end
    end

    assign win_valid = bus.req_valid_in[winner_q];

    // state and holding registers, cleared asynchronously
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            last_grant_q <= 2'(NUM_REQ - 1);
            winner_q     <= '0;
            grant_id_q   <= '0;
            msg_q        <= '0;
            hdr_q        <= '0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            grant_id_q   <= grant_id_d;
            msg_q        <= msg_d;
            hdr_q        <= hdr_d;
            sent_count_q <= sent_count_d;
        end
    end

    // next state: pick in IDLE, capture in GRANT only if the winner is still valid, count acceptances
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        grant_id_d   = grant_id_q;
        msg_d        = msg_q;
        hdr_d        = hdr_q;
        sent_count_d = sent_count_q;
        case (state_q)
            IDLE: begin
                if (bus.remote_stall_in) state_d = PAUSED;
                else if (|bus.req_valid_in) begin
                    state_d  = GRANT;
                    winner_d = pick;
                end
            end
            GRANT: begin
                state_d = win_valid ? HOLD : IDLE;
                if (win_valid) begin
                    last_grant_d = winner_q;
                    grant_id_d   = winner_q;
                    msg_d        = bus.req_message_in[winner_q*MESSAGE_SIZE +: MESSAGE_SIZE];
                    hdr_d        = bus.req_header_in[winner_q*HEADER_SIZE +: HEADER_SIZE];
                end
            end
            HOLD: begin
                if (bus.tx_ready_in) begin
                    state_d      = IDLE;
                    sent_count_d = sent_count_q + 16'd1;
                end
            end
            PAUSED: state_d = bus.remote_stall_in ? PAUSED : IDLE;
        endcase
    end

    // outputs decoded from state; header low bits carry the source tag
    always_comb begin
        bus.tx_valid_out   = state_q == HOLD;
        bus.req_ready_out  = (state_q == GRANT && win_valid) ? NUM_REQ'(1) << winner_q : '0;
        bus.tx_message_out = msg_q;
        bus.tx_header_out  = {hdr_q[HEADER_SIZE-1:2], grant_id_q};
        bus.grant_id_out   = grant_id_q;
        bus.sent_count_out = sent_count_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for the UART TX arbiter
module tb_uart_tx_arbiter;
    localparam int MS = 64;
    localparam int HS = 32;
    localparam int NR = 3;

    typedef struct {
        logic [1:0]    id;
        logic [HS-1:0] hdr;
        logic [MS-1:0] msg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [HS-1:0] hdr_r [NR];
    logic [MS-1:0] msg_r [NR];
    exp_t          sb [$];
    int            checks = 0;
    int            errors = 0;
    int            ready_cnt = 0;
    int            r0;

    uart_tx_arbiter_if #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS), .NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS), .NUM_REQ(NR)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    assign bus.req_header_in  = {hdr_r[2], hdr_r[1], hdr_r[0]};
    assign bus.req_message_in = {msg_r[2], msg_r[1], msg_r[0]};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 2'(id);
        e.hdr = {hdr_r[id][HS-1:2], 2'(id)};
        e.msg = msg_r[id];
        sb.push_back(e);
    endtask

    task automatic wait_tx_valid(input string tag);
        int n = 0;
        while (bus.tx_valid_out !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait_valid"}, 64'(bus.tx_valid_out), 64'd1);
    endtask

    // monitor samples just before each rising edge: grant pulses and acceptances
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (rst === 1'b0 && bus.req_ready_out !== '0) begin
            ready_cnt++;
            if (sb.size() > 0) chk("ready_id", 64'(bus.req_ready_out), 64'(3'b001 << sb[0].id));
        end
        if (rst === 1'b0 && bus.tx_valid_out === 1'b1 && bus.tx_ready_in === 1'b1) begin
            chk("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("acc_grant", 64'(bus.grant_id_out), 64'(e.id));
                chk("acc_hdr", 64'(bus.tx_header_out), 64'(e.hdr));
                chk("acc_msg", bus.tx_message_out, e.msg);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.req_valid_in    = '0;
        bus.tx_ready_in     = 1'b0;
        bus.remote_stall_in = 1'b0;
        hdr_r[0] = 32'h1234_5670;
        hdr_r[1] = 32'hA5A5_A5A0;
        hdr_r[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < NR; i++) msg_r[i] = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.tx_valid_out), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_out), 64'd0);
        chk("rst_grant", 64'(bus.grant_id_out), 64'd0);
        chk("rst_count", 64'(bus.sent_count_out), 64'd0);
        chk("rst_hdr", 64'(bus.tx_header_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single request from requester 1
        bus.req_valid_in = 3'b010;
        bus.tx_ready_in  = 1'b1;
        push_exp(1);
        r0 = ready_cnt;
        @(negedge clk);
        chk("t1_ready", 64'(bus.req_ready_out), 64'b010);
        chk("t1_valid_early", 64'(bus.tx_valid_out), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(bus.tx_valid_out), 64'd1);
        chk("t1_ready_hold", 64'(bus.req_ready_out), 64'd0);
        chk("t1_hdr", 64'(bus.tx_header_out), 64'hA5A5_A5A1);
        chk("t1_grant", 64'(bus.grant_id_out), 64'd1);
        bus.req_valid_in = '0;
        @(negedge clk);
        chk("t1_valid_drop", 64'(bus.tx_valid_out), 64'd0);
        chk("t1_count", 64'(bus.sent_count_out), 64'd1);
        chk("t1_pulses", 64'(ready_cnt - r0), 64'd1);

        // fairness from a fresh reset: 0,1,2,0,1,2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) push_exp(i % NR);
        r0 = ready_cnt;
        bus.req_valid_in = 3'b111;
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        chk("fair_drain", 64'(sb.size()), 64'd0);
        bus.req_valid_in = '0;
        chk("fair_count", 64'(bus.sent_count_out), 64'd6);
        chk("fair_pulses", 64'(ready_cnt - r0), 64'd6);

        // backpressure: 20 cycles held stable, then one acceptance
        bus.tx_ready_in  = 1'b0;
        bus.req_valid_in = 3'b001;
        push_exp(0);
        wait_tx_valid("bp");
        bus.req_valid_in = '0;
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 64'(bus.tx_valid_out), 64'd1);
            chk("bp_msg", bus.tx_message_out, msg_r[0]);
            chk("bp_ready", 64'(bus.req_ready_out), 64'd0);
            @(negedge clk);
        end
        bus.tx_ready_in = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 64'(bus.tx_valid_out), 64'd0);
        chk("bp_count", 64'(bus.sent_count_out), 64'd7);

        // stall blocks grants; stall during HOLD does not abort
        bus.tx_ready_in     = 1'b0;
        bus.remote_stall_in = 1'b1;
        bus.req_valid_in    = 3'b001;
        r0 = ready_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("st_ready", 64'(bus.req_ready_out), 64'd0);
            chk("st_valid", 64'(bus.tx_valid_out), 64'd0);
        end
        push_exp(0);
        bus.remote_stall_in = 1'b0;
        wait_tx_valid("st");
        bus.req_valid_in    = '0;
        bus.remote_stall_in = 1'b1;
        @(negedge clk);
        chk("st_hold_valid", 64'(bus.tx_valid_out), 64'd1);
        bus.tx_ready_in = 1'b1;
        @(negedge clk);
        chk("st_valid_drop", 64'(bus.tx_valid_out), 64'd0);
        chk("st_count", 64'(bus.sent_count_out), 64'd8);
        chk("st_pulses", 64'(ready_cnt - r0), 64'd1);
        bus.remote_stall_in = 1'b0;
        @(negedge clk);

        // asynchronous reset mid-HOLD drops the message
        bus.tx_ready_in  = 1'b0;
        bus.req_valid_in = 3'b010;
        wait_tx_valid("rh");
        bus.req_valid_in = '0;
        #2 rst = 1'b1;
        #1;
        chk("rh_valid", 64'(bus.tx_valid_out), 64'd0);
        chk("rh_count", 64'(bus.sent_count_out), 64'd0);
        chk("rh_grant", 64'(bus.grant_id_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(0);
        bus.req_valid_in = 3'b111;
        bus.tx_ready_in  = 1'b1;
        wait_tx_valid("rh2");
        bus.req_valid_in = '0;
        @(negedge clk);
        chk("rh_count_after", 64'(bus.sent_count_out), 64'd1);

        // counter wrap after preloading 0xFFFF acceptances
        force dut.sent_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.sent_count_q;
        @(negedge clk);
        chk("wr_preload", 64'(bus.sent_count_out), 64'hFFFF);
        push_exp(2);
        bus.req_valid_in = 3'b100;
        wait_tx_valid("wr");
        bus.req_valid_in = '0;
        @(negedge clk);
        chk("wr_count", 64'(bus.sent_count_out), 64'h0000);
        chk("wr_valid_drop", 64'(bus.tx_valid_out), 64'd0);

        repeat (2) @(negedge clk);
        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter MESSAGE_SIZE, default 512, payload width in bits.
REQ-002 SHALL have parameter HEADER_SIZE, default 32, header width in bits (minimum 8).
REQ-003 SHALL have parameter NUM_REQ, default 3, number of requesters (2..4).
REQ-004 SHALL have port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid_in, input, NUM_REQ, per-requester message-available flags.
REQ-007 SHALL have port req_ready_out, output, NUM_REQ, per-requester accept strobes.
REQ-008 SHALL have port req_message_in, input, NUM_REQ*MESSAGE_SIZE, requester i payload at slice [i*MESSAGE_SIZE +: MESSAGE_SIZE].
REQ-009 SHALL have port req_header_in, input, NUM_REQ*HEADER_SIZE, requester i header at slice [i*HEADER_SIZE +: HEADER_SIZE].
REQ-010 SHALL have port tx_valid_out, output, 1, held message valid toward the UART controller TX port.
REQ-011 SHALL have port tx_ready_in, input, 1, UART controller ready for a new message.
REQ-012 SHALL have port tx_message_out, output, MESSAGE_SIZE, held payload.
REQ-013 SHALL have port tx_header_out, output, HEADER_SIZE, held header with source tag.
REQ-014 SHALL have port remote_stall_in, input, 1, host-side stall; blocks new grants while high.
REQ-015 SHALL have port grant_id_out, output, 2, index of the requester that owns the held message.
REQ-016 SHALL have port sent_count_out, output, 16, count of messages accepted downstream.

Function
REQ-017 SHALL implement states IDLE, GRANT, HOLD, PAUSED.
REQ-018 SHALL, in IDLE with remote_stall_in low and any req_valid_in bit high, select a winner round-robin from (last_grant+1) mod NUM_REQ upward, and go to GRANT.
REQ-019 SHALL, in GRANT, drive req_ready_out one-hot for the winner for exactly one cycle; that cycle is the transfer cycle.
REQ-020 SHALL, in GRANT, capture the winner's message and header into holding registers and set last_grant to the winner.
REQ-021 SHALL form tx_header_out as captured header with bits [1:0] replaced by the winner index; all other bits pass unchanged.
REQ-022 SHALL go GRANT -> HOLD, asserting tx_valid_out from the first HOLD cycle; valid_in-to-tx_valid_out latency is 2 cycles.
REQ-023 SHALL hold tx_valid_out, tx_message_out, tx_header_out and grant_id_out stable in HOLD until a cycle with tx_valid_out and tx_ready_in both high.
REQ-024 SHALL, on that acceptance, deassert tx_valid_out next cycle, increment sent_count_out (wraps 0xFFFF -> 0x0000), and return to IDLE.
REQ-025 SHALL not grant a requester whose req_valid_in dropped before GRANT; if the winner's req_valid_in is low in GRANT, req_ready_out stays 0, nothing is captured, and state returns to IDLE.
REQ-026 SHALL, in IDLE with remote_stall_in high, go to PAUSED; in PAUSED drive all req_ready_out low and return to IDLE on the first cycle remote_stall_in is low.
REQ-027 SHALL not abort a message already in HOLD when remote_stall_in rises; the held message completes normally.
REQ-028 SHALL grant at most one requester per message; with all requesters continuously valid, grants SHALL cycle 0,1,..,NUM_REQ-1,0.
REQ-029 SHALL drive req_ready_out to 0 in IDLE, HOLD and PAUSED.

Reset
REQ-030 SHALL on rst_in high immediately force: state IDLE, tx_valid_out 0, req_ready_out 0, grant_id_out 0, sent_count_out 0, last_grant NUM_REQ-1, holding registers 0.
REQ-031 SHALL, on reset mid-HOLD, drop the held message without acceptance and not increment sent_count_out.

Verification
REQ-032 Single request: req_valid_in=3'b010, header 0xA5A5A5A0, tx_ready_in=1 -> req_ready_out=3'b010 one cycle, tx_valid_out 2 cycles after valid, tx_header_out=0xA5A5A5A1, grant_id_out=1, sent_count_out=1.
REQ-033 Fairness: all three valid constantly, tx_ready_in=1 -> grant sequence 0,1,2,0,1,2; sent_count_out=6 after six acceptances.
REQ-034 Backpressure: tx_ready_in=0 for 20 cycles in HOLD -> tx_valid_out and tx_message_out stable all 20 cycles, no req_ready_out pulse; raise tx_ready_in -> one acceptance.
REQ-035 Stall: remote_stall_in=1 with requester 0 valid -> no req_ready_out while high; stall rising during HOLD -> held message still accepted.
REQ-036 Reset mid-HOLD: assert rst_in asynchronously -> tx_valid_out 0 before next edge, sent_count_out 0, next grant goes to requester 0.
REQ-037 Counter wrap: preload by 65535 acceptances -> next acceptance gives sent_count_out=0x0000.
